wb_regfile: RTL and testbench

- Write-back stage plus architectural register file for the 5-stage pipeline CPU.
- Consumes the MEM/WB pipeline register outputs and selects write data (load data or ALU result).
- Commits the selected value to the 32x32 register file and serves the two ID-stage read ports with same-cycle write bypass.
- Provides a write-back event counter and a serial register-dump port for bench and debug use.

---
 rtl/wb_regfile_if.sv | 33 +++
 rtl/wb_regfile.sv | 112 +++++++++++
 tb/tb_wb_regfile.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// MEM/WB, register read-port and dump signals shared between wb_regfile and its driver.
// The slave modport is the register file's view.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              regWriteIn;
  logic              memToRegIn;
  logic [DATA_W-1:0] rdIn;
  logic [DATA_W-1:0] aluIn;
  logic [ADDR_W-1:0] wnIn;
  logic [ADDR_W-1:0] rsAddr;
  logic [ADDR_W-1:0] rtAddr;
  logic [DATA_W-1:0] rsData;
  logic [DATA_W-1:0] rtData;
  logic [DATA_W-1:0] wbData;
  logic [31:0]       wbCount;
  logic              dumpReq;
  logic              dumpValid;
  logic [ADDR_W-1:0] dumpIdx;
  logic [DATA_W-1:0] dumpData;
  logic              dumpDone;

  modport slave (
    input  regWriteIn, memToRegIn, rdIn, aluIn, wnIn, rsAddr, rtAddr, dumpReq,
    output rsData, rtData, wbData, wbCount, dumpValid, dumpIdx, dumpData, dumpDone
  );

  modport master (
    output regWriteIn, memToRegIn, rdIn, aluIn, wnIn, rsAddr, rtAddr, dumpReq,
    input  rsData, rtData, wbData, wbCount, dumpValid, dumpIdx, dumpData, dumpDone
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage and 32-entry register file with bypassed read ports,
// a commit counter and a serial register-dump port.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int REG_N  = 32
) (
  input logic         clk,
  input logic         rst,
  wb_regfile_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DUMP, DONE} state_e;

  logic [DATA_W-1:0] regs_q [REG_N];
  logic [DATA_W-1:0] regs_d [REG_N];
  logic [31:0]       wb_count_q, wb_count_d;
  state_e            state_q, state_d;
  logic              dump_valid_q, dump_valid_d;
  logic              dump_done_q, dump_done_d;
  logic [ADDR_W-1:0] dump_idx_q, dump_idx_d;
  logic [DATA_W-1:0] dump_data_q, dump_data_d;

  logic [DATA_W-1:0] wb_data;
  logic              commit;
  logic [ADDR_W-1:0] dump_next_idx;

  // Index 0 never bypasses since a write to it is never a commit.
  function automatic logic [DATA_W-1:0] bypass_read(input logic [ADDR_W-1:0] a);
    if (a == '0)
      return '0;
    else if (bus.regWriteIn && (bus.wnIn == a))
      return wb_data;
    else
      return regs_q[a];
  endfunction

  assign wb_data       = bus.memToRegIn ? bus.rdIn : bus.aluIn;
  assign commit        = bus.regWriteIn && (bus.wnIn != '0);
  assign dump_next_idx = dump_idx_q + ADDR_W'(1);

  always_comb begin
    regs_d = regs_q;
    if (commit)
      regs_d[bus.wnIn] = wb_data;
    wb_count_d = wb_count_q + {31'd0, commit};
  end

  always_comb begin
    state_d      = state_q;
    dump_valid_d = dump_valid_q;
    dump_done_d  = 1'b0;
    dump_idx_d   = dump_idx_q;
    dump_data_d  = dump_data_q;
    case (state_q)
      IDLE: begin
        if (bus.dumpReq) begin
          state_d      = DUMP;
          dump_valid_d = 1'b1;
          dump_idx_d   = '0;
          dump_data_d  = '0;
        end
      end
      DUMP: begin
        if (dump_idx_q == ADDR_W'(REG_N - 1)) begin
          state_d      = DONE;
          dump_valid_d = 1'b0;
          dump_done_d  = 1'b1;
        end else begin
          dump_idx_d  = dump_next_idx;
          dump_data_d = bypass_read(dump_next_idx);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d      = IDLE;
        dump_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < REG_N; i++)
        regs_q[i] <= '0;
      wb_count_q   <= '0;
      state_q      <= IDLE;
      dump_valid_q <= 1'b0;
      dump_done_q  <= 1'b0;
      dump_idx_q   <= '0;
      dump_data_q  <= '0;
    end else begin
      regs_q       <= regs_d;
      wb_count_q   <= wb_count_d;
      state_q      <= state_d;
      dump_valid_q <= dump_valid_d;
      dump_done_q  <= dump_done_d;
      dump_idx_q   <= dump_idx_d;
      dump_data_q  <= dump_data_d;
    end
  end

  assign bus.wbData    = wb_data;
  assign bus.rsData    = bypass_read(bus.rsAddr);
  assign bus.rtData    = bypass_read(bus.rtAddr);
  assign bus.wbCount   = wb_count_q;
  assign bus.dumpValid = dump_valid_q;
  assign bus.dumpIdx   = dump_idx_q;
  assign bus.dumpData  = dump_data_q;
  assign bus.dumpDone  = dump_done_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized traffic
// compared against an array-based register-file model.
module tb_wb_regfile;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;

  logic [31:0] model [32];
  logic [31:0] model_count;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .REG_N(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_wb();
    return bus.memToRegIn ? bus.rdIn : bus.aluIn;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (bus.regWriteIn && bus.wnIn == a) return exp_wb();
    return model[a];
  endfunction

  // Update the model with what the coming edge should do, then pass the edge.
  task automatic step();
    if (!rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      model_count = 32'd0;
    end else if (bus.regWriteIn && bus.wnIn != 5'd0) begin
      model[bus.wnIn] = exp_wb();
      model_count = model_count + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.regWriteIn = 1'b0;
    bus.memToRegIn = 1'b0;
    bus.rdIn       = 32'd0;
    bus.aluIn      = 32'd0;
    bus.wnIn       = 5'd0;
    bus.rsAddr     = 5'd0;
    bus.rtAddr     = 5'd0;
    bus.dumpReq    = 1'b0;
  endtask

  task automatic write_reg(input logic [4:0] wn, input logic [31:0] v);
    bus.regWriteIn = 1'b1;
    bus.memToRegIn = 1'b0;
    bus.aluIn      = v;
    bus.wnIn       = wn;
    step();
    bus.regWriteIn = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    bus.regWriteIn = 1'b1;
    bus.wnIn       = 5'd5;
    bus.aluIn      = 32'hDEAD;
    step();
    step();
    rst = 1'b1;
    bus.regWriteIn = 1'b0;
    bus.rsAddr     = 5'd5;
    #1;
    checks++;
    if (bus.rsData !== 32'd0) begin
      failures++; $display("FAIL reset_rs5 got=%h exp=%h", bus.rsData, 32'd0);
    end
    checks++;
    if (bus.wbCount !== 32'd0) begin
      failures++; $display("FAIL reset_count got=%h exp=%h", bus.wbCount, 32'd0);
    end
    checks++;
    if (bus.dumpValid !== 1'b0 || bus.dumpDone !== 1'b0) begin
      failures++; $display("FAIL reset_dump got=%b%b exp=00", bus.dumpValid, bus.dumpDone);
    end
  endtask

  task automatic test_write_mux();
    bus.regWriteIn = 1'b1;
    bus.memToRegIn = 1'b0;
    bus.aluIn      = 32'h1234;
    bus.rdIn       = 32'h9999;
    bus.wnIn       = 5'd8;
    #1;
    checks++;
    if (bus.wbData !== 32'h1234) begin
      failures++; $display("FAIL mux_alu got=%h exp=%h", bus.wbData, 32'h1234);
    end
    step();
    bus.memToRegIn = 1'b1;
    bus.rdIn       = 32'hABCD;
    bus.wnIn       = 5'd9;
    #1;
    checks++;
    if (bus.wbData !== 32'hABCD) begin
      failures++; $display("FAIL mux_mem got=%h exp=%h", bus.wbData, 32'hABCD);
    end
    step();
    bus.regWriteIn = 1'b0;
    bus.rsAddr = 5'd8;
    bus.rtAddr = 5'd9;
    #1;
    checks++;
    if (bus.rsData !== 32'h1234 || bus.rtData !== 32'hABCD) begin
      failures++; $display("FAIL mux_read got=%h/%h exp=%h/%h", bus.rsData, bus.rtData, 32'h1234, 32'hABCD);
    end
    checks++;
    if (bus.wbCount !== 32'd2) begin
      failures++; $display("FAIL mux_count got=%h exp=%h", bus.wbCount, 32'd2);
    end
  endtask

  task automatic test_bypass_r0();
    logic [31:0] cnt_before;
    bus.regWriteIn = 1'b1;
    bus.memToRegIn = 1'b0;
    bus.wnIn   = 5'd3;
    bus.aluIn  = 32'h55;
    bus.rsAddr = 5'd3;
    bus.rtAddr = 5'd3;
    #1;
    checks++;
    if (bus.rsData !== 32'h55 || bus.rtData !== 32'h55) begin
      failures++; $display("FAIL bypass got=%h/%h exp=%h", bus.rsData, bus.rtData, 32'h55);
    end
    step();
    cnt_before = model_count;
    bus.wnIn   = 5'd0;
    bus.aluIn  = 32'hFF;
    bus.rsAddr = 5'd0;
    bus.rtAddr = 5'd0;
    #1;
    checks++;
    if (bus.rsData !== 32'd0 || bus.rtData !== 32'd0) begin
      failures++; $display("FAIL r0_bypass got=%h/%h exp=%h", bus.rsData, bus.rtData, 32'd0);
    end
    step();
    bus.regWriteIn = 1'b0;
    #1;
    checks++;
    if (bus.rsData !== 32'd0) begin
      failures++; $display("FAIL r0_read got=%h exp=%h", bus.rsData, 32'd0);
    end
    checks++;
    if (bus.wbCount !== cnt_before) begin
      failures++; $display("FAIL r0_count got=%h exp=%h", bus.wbCount, cnt_before);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      bus.regWriteIn = 1'($urandom_range(0, 1));
      bus.memToRegIn = 1'($urandom_range(0, 1));
      bus.rdIn       = $urandom;
      bus.aluIn      = $urandom;
      bus.wnIn       = 5'($urandom_range(0, 31));
      bus.rsAddr     = ($urandom_range(0, 3) == 0) ? bus.wnIn : 5'($urandom_range(0, 31));
      bus.rtAddr     = ($urandom_range(0, 3) == 0) ? bus.wnIn : 5'($urandom_range(0, 31));
      #1;
      checks++;
      if (bus.wbData !== exp_wb() || bus.rsData !== exp_read(bus.rsAddr) || bus.rtData !== exp_read(bus.rtAddr)) begin
        failures++;
        $display("FAIL rand_read n=%0d got=%h/%h/%h exp=%h/%h/%h", n, bus.wbData, bus.rsData, bus.rtData,
                 exp_wb(), exp_read(bus.rsAddr), exp_read(bus.rtAddr));
      end
      step();
      checks++;
      if (bus.wbCount !== model_count) begin
        failures++; $display("FAIL rand_count n=%0d got=%h exp=%h", n, bus.wbCount, model_count);
      end
    end
    idle_inputs();
  endtask

  // Runs one full dump already started; beat k must show model[k] as of that edge.
  task automatic run_dump(input string tag, input bit rand_writes, input bit hold_req);
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (bus.dumpValid !== 1'b1 || bus.dumpIdx !== 5'(k) || bus.dumpData !== model[k] || bus.dumpDone !== 1'b0) begin
        failures++;
        $display("FAIL %s_beat k=%0d got=v%b i%0d d%h exp=v1 i%0d d%h", tag, k, bus.dumpValid, bus.dumpIdx,
                 bus.dumpData, k, model[k]);
      end
      bus.dumpReq = hold_req || (k == 5) || (k == 6);
      bus.regWriteIn = 1'b0;
      if (rand_writes) begin
        bus.regWriteIn = 1'($urandom_range(0, 1));
        bus.memToRegIn = 1'($urandom_range(0, 1));
        bus.rdIn       = $urandom;
        bus.aluIn      = $urandom;
        bus.wnIn       = ($urandom_range(0, 1) == 1) ? 5'((k + 1) % 32) : 5'($urandom_range(0, 31));
        if (k == 19) begin
          bus.regWriteIn = 1'b1;
          bus.memToRegIn = 1'b0;
          bus.aluIn      = 32'h777;
          bus.wnIn       = 5'd20;
        end
      end
      step();
    end
    bus.regWriteIn = 1'b0;
    checks++;
    if (bus.dumpDone !== 1'b1 || bus.dumpValid !== 1'b0) begin
      failures++; $display("FAIL %s_done got=d%b v%b exp=d1 v0", tag, bus.dumpDone, bus.dumpValid);
    end
    step();
    checks++;
    if (bus.dumpDone !== 1'b0 || bus.dumpValid !== 1'b0) begin
      failures++; $display("FAIL %s_idle got=d%b v%b exp=d0 v0", tag, bus.dumpDone, bus.dumpValid);
    end
  endtask

  task automatic test_dump();
    for (int k = 1; k < 32; k++) write_reg(5'(k), 32'(k * 16));
    bus.dumpReq = 1'b1;
    step();
    bus.dumpReq = 1'b0;
    run_dump("dump", 1'b0, 1'b0);
    step();
    checks++;
    if (bus.dumpValid !== 1'b0) begin
      failures++; $display("FAIL dump_noretrig got=%b exp=0", bus.dumpValid);
    end
  endtask

  task automatic test_write_during_dump();
    bus.dumpReq = 1'b1;
    step();
    run_dump("wdump", 1'b1, 1'b1);
    checks++;
    if (model[20] !== 32'h777 && bus.dumpValid !== 1'b0) begin
      failures++; $display("FAIL wdump_model got=%h exp=%h", model[20], 32'h777);
    end
    step();
    checks++;
    if (bus.dumpValid !== 1'b1 || bus.dumpIdx !== 5'd0) begin
      failures++; $display("FAIL retrigger got=v%b i%0d exp=v1 i0", bus.dumpValid, bus.dumpIdx);
    end
  endtask

  task automatic test_reset_mid_dump();
    bus.dumpReq = 1'b0;
    for (int k = 0; k < 40 && bus.dumpIdx !== 5'd10; k++) step();
    checks++;
    if (bus.dumpIdx !== 5'd10 || bus.dumpValid !== 1'b1) begin
      failures++; $display("FAIL midreset_reach got=i%0d v%b exp=i10 v1", bus.dumpIdx, bus.dumpValid);
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks++;
    if (bus.dumpValid !== 1'b0 || bus.dumpDone !== 1'b0 || bus.dumpIdx !== 5'd0 || bus.dumpData !== 32'd0) begin
      failures++; $display("FAIL midreset_dump got=v%b d%b i%0d %h exp=v0 d0 i0 0", bus.dumpValid, bus.dumpDone,
                           bus.dumpIdx, bus.dumpData);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (bus.dumpDone !== 1'b0 || bus.dumpValid !== 1'b0) begin
        failures++; $display("FAIL midreset_nodone k=%0d got=d%b v%b exp=d0 v0", k, bus.dumpDone, bus.dumpValid);
      end
    end
    for (int a = 0; a < 32; a++) begin
      bus.rsAddr = 5'(a);
      bus.rtAddr = 5'(31 - a);
      #1;
      checks++;
      if (bus.rsData !== 32'd0 || bus.rtData !== 32'd0) begin
        failures++; $display("FAIL midreset_regs a=%0d got=%h/%h exp=0", a, bus.rsData, bus.rtData);
      end
    end
    checks++;
    if (bus.wbCount !== 32'd0) begin
      failures++; $display("FAIL midreset_count got=%h exp=%h", bus.wbCount, 32'd0);
    end
  endtask

  task automatic test_counter_wrap();
    force dut.wb_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.wb_count_q;
    model_count = 32'hFFFF_FFFF;
    write_reg(5'd7, 32'h1);
    checks++;
    if (bus.wbCount !== 32'd0) begin
      failures++; $display("FAIL wrap got=%h exp=%h", bus.wbCount, 32'd0);
    end
    write_reg(5'd7, 32'h2);
    checks++;
    if (bus.wbCount !== model_count) begin
      failures++; $display("FAIL wrap_next got=%h exp=%h", bus.wbCount, model_count);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    model_count = 32'd0;
    idle_inputs();
    #1;
    test_reset();
    test_write_mux();
    test_bypass_r0();
    test_random();
    test_dump();
    test_write_during_dump();
    test_reset_mid_dump();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
